// File: rtl/dense_layer_mac.sv
// Fully-connected layer sequencer: streams weights/activations from external
// registered-read memories, accumulates bias + dot product, emits saturated Q8.8.
// Optional DENSE_RELU_EN clamps negative results to zero (hidden layers).
module dense_layer_mac #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 16,
  parameter int FRAC_BITS  = 8,
  parameter int N_IN       = 784,
  parameter int N_OUT      = 10,
  parameter int ACC_WIDTH  = 40
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] w_addr,
  input  logic [DATA_WIDTH-1:0] w_q,
  output logic [ADDR_WIDTH-1:0] x_addr,
  input  logic [DATA_WIDTH-1:0] x_q,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [7:0]            out_idx
);

  localparam longint ROM_WORDS = longint'(N_OUT) * longint'(N_IN) + longint'(N_OUT);

  if (ROM_WORDS > (longint'(1) << ADDR_WIDTH) || N_OUT > 256) begin : g_cfg_err
    $error("dense_layer_mac: weight ROM does not fit ADDR_WIDTH or N_OUT > 256");
  end

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_BIAS  = 3'd1;
  localparam logic [2:0] S_MAC   = 3'd2;
  localparam logic [2:0] S_DRAIN = 3'd3;
  localparam logic [2:0] S_OUT   = 3'd4;
  localparam logic [2:0] S_FIN   = 3'd5;

  localparam logic [ADDR_WIDTH-1:0] BIAS_BASE = ADDR_WIDTH'(N_OUT * N_IN);
  localparam logic [ADDR_WIDTH-1:0] LAST_I    = ADDR_WIDTH'(N_IN - 1);
  localparam logic [7:0]            LAST_J    = 8'(N_OUT - 1);

  logic [2:0]                   state;
  logic [7:0]                   j;
  logic [ADDR_WIDTH-1:0]        i;
  logic signed [ACC_WIDTH-1:0]  acc;

  logic signed [2*DATA_WIDTH-1:0] prod;
  logic signed [ACC_WIDTH-1:0]    prod_ext, bias_ext, acc_sum, shifted;
  logic [DATA_WIDTH-1:0]          res;

  // Datapath: data on w_q/x_q always belongs to the address issued last cycle.
  always_comb begin
    prod     = $signed(w_q) * $signed(x_q);
    prod_ext = {{(ACC_WIDTH-2*DATA_WIDTH){prod[2*DATA_WIDTH-1]}}, prod};
    bias_ext = {{(ACC_WIDTH-DATA_WIDTH){w_q[DATA_WIDTH-1]}}, w_q};
    bias_ext = bias_ext <<< FRAC_BITS;
    acc_sum  = acc + prod_ext;
    shifted  = acc_sum >>> FRAC_BITS;
    res      = shifted[DATA_WIDTH-1:0];
    if (shifted > $signed({{(ACC_WIDTH-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}}))
      res = {1'b0, {(DATA_WIDTH-1){1'b1}}};
    else if (shifted < $signed({{(ACC_WIDTH-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}}))
      res = {1'b1, {(DATA_WIDTH-1){1'b0}}};
`ifdef DENSE_RELU_EN
    if (res[DATA_WIDTH-1]) res = '0;
`endif
  end

  // Addresses are registered so they hold their last value through DRAIN/OUT.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      j        <= '0;
      i        <= '0;
      acc      <= '0;
      w_addr   <= '0;
      x_addr   <= '0;
      out_data <= '0;
    end else begin
      case (state)
        S_IDLE: if (start) begin
          j      <= '0;
          w_addr <= BIAS_BASE;
          x_addr <= '0;
          state  <= S_BIAS;
        end
        S_BIAS: begin
          w_addr <= ADDR_WIDTH'(j * N_IN);
          x_addr <= '0;
          i      <= '0;
          state  <= S_MAC;
        end
        S_MAC: begin
          acc <= (i == '0) ? bias_ext : acc_sum;
          if (i == LAST_I) begin
            state <= S_DRAIN;
          end else begin
            i      <= i + ADDR_WIDTH'(1);
            w_addr <= w_addr + ADDR_WIDTH'(1);
            x_addr <= x_addr + ADDR_WIDTH'(1);
          end
        end
        S_DRAIN: begin
          acc      <= acc_sum;
          out_data <= res;
          state    <= S_OUT;
        end
        S_OUT: if (out_ready) begin
          if (j == LAST_J) begin
            state <= S_FIN;
          end else begin
            j      <= j + 8'd1;
            w_addr <= BIAS_BASE + ADDR_WIDTH'(j) + ADDR_WIDTH'(1);
            x_addr <= '0;
            state  <= S_BIAS;
          end
        end
        S_FIN:   state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign busy      = (state != S_IDLE);
  assign done      = (state == S_FIN);
  assign out_valid = (state == S_OUT);
  assign out_idx   = j;

endmodule

// File: tb/tb_dense_layer_mac.sv
// Self-checking bench for dense_layer_mac (N_IN=4, N_OUT=2) with a behavioural
// ROM/activation model and an arithmetic reference for each neuron result.
module tb_dense_layer_mac;
  localparam int N_IN  = 4;
  localparam int N_OUT = 2;
  localparam int BBASE = N_OUT * N_IN;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        out_ready = 1'b1;
  logic        busy, done, out_valid;
  logic [15:0] w_addr, x_addr, w_q, x_q, out_data;
  logic [7:0]  out_idx;

  logic signed [15:0] rom  [0:65535];
  logic signed [15:0] xmem [0:65535];

  int n_chk = 0, n_fail = 0, hs_cnt = 0, done_cnt = 0;
  logic [23:0] exp_q[$];
  int wt[$], xt[$];
  bit trace_en = 1'b0;

  dense_layer_mac #(.N_IN(N_IN), .N_OUT(N_OUT)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
    .w_addr(w_addr), .w_q(w_q), .x_addr(x_addr), .x_q(x_q),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_idx(out_idx)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    w_q <= rom[w_addr];
    x_q <= xmem[x_addr];
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] model(input int j);
    longint acc;
    acc = longint'(rom[BBASE + j]) * 256;
    for (int k = 0; k < N_IN; k++)
      acc += longint'(rom[j*N_IN + k]) * longint'(xmem[k]);
    acc = acc >>> 8;
    if (acc > 32767) acc = 32767;
    else if (acc < -32768) acc = -32768;
`ifdef DENSE_RELU_EN
    if (acc < 0) acc = 0;
`endif
    return 16'(acc);
  endfunction

  // Scoreboard: every accepted result must match the next expected neuron.
  always @(negedge clk) begin
    if (rst_n) begin
      if (done) done_cnt++;
      if (out_valid && out_ready) begin
        logic [23:0] e;
        hs_cnt++;
        if (exp_q.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL extra_result: got idx %0d data %h expected no result", out_idx, out_data);
        end else begin
          e = exp_q.pop_front();
          check("out_idx", 64'(out_idx), 64'(e[23:16]));
          check("out_data", 64'(out_data), 64'(e[15:0]));
        end
      end
      if (trace_en && busy) begin
        if (wt.size() == 0 || wt[$] != int'(w_addr)) wt.push_back(int'(w_addr));
        if (xt.size() == 0 || xt[$] != int'(x_addr)) xt.push_back(int'(x_addr));
      end
    end
  end

  task automatic set_data(input logic [15:0] w0, input logic [15:0] w1, input logic [15:0] b0,
                          input logic [15:0] b1, input logic [15:0] xv [4], input bit alt);
    for (int k = 0; k < N_IN; k++) begin
      rom[k]        = (alt && k == 1) ? 16'hFF00 : (alt && k == 2) ? 16'h0080 :
                      (alt && k == 3) ? 16'h0000 : w0;
      rom[N_IN + k] = w1;
      xmem[k]       = xv[k];
    end
    rom[BBASE]     = b0;
    rom[BBASE + 1] = b1;
  endtask

  task automatic load_exp();
    for (int j = 0; j < N_OUT; j++) exp_q.push_back({8'(j), model(j)});
  endtask

  task automatic do_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic wait_done(input string tag, output int n);
    n = 0;
    while (!done && n < 2000) begin @(posedge clk); #1; n++; end
    check({tag, "_done"}, 64'(done), 64'd1);
    @(posedge clk); #1;
    check({tag, "_done_pulse"}, 64'({busy, done}), 64'd0);
  endtask

  task automatic simple_pass(input string tag);
    int n, h0, d0;
    h0 = hs_cnt; d0 = done_cnt;
    load_exp();
    do_start();
    wait_done(tag, n);
    check({tag, "_results"}, 64'(hs_cnt - h0), 64'(N_OUT));
    check({tag, "_done_cnt"}, 64'(done_cnt - d0), 64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] xv [4];
    int n, lat, h0, d0;
    int wexp [10] = '{8, 0, 1, 2, 3, 9, 4, 5, 6, 7};
    int xexp [8]  = '{0, 1, 2, 3, 0, 1, 2, 3};
    logic [15:0] od, wa, xa;
    logic [7:0]  oi;

    for (int k = 0; k < 16; k++) begin rom[k] = '0; xmem[k] = '0; end
    xv = '{16'h0100, 16'h0200, 16'h0300, 16'h0400};
    set_data(16'h0100, 16'h0100, 16'h0080, 16'h0080, xv, 1'b0);

    #12;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_valid", 64'(out_valid), 64'd0);
    check("rst_data_idx", 64'({out_data, out_idx}), 64'd0);
    check("rst_addr", 64'({w_addr, x_addr}), 64'd0);
    @(posedge clk); #1 rst_n = 1'b1;

    // Basic pass: latency, period, address trace.
    check("model_pin_basic", 64'(model(0)), 64'h0A80);
    h0 = hs_cnt; d0 = done_cnt;
    load_exp();
    wt.delete(); xt.delete(); trace_en = 1'b1;
    do_start();
    check("busy_after_start", 64'(busy), 64'd1);
    lat = 0;
    while (!out_valid && lat < 50) begin @(posedge clk); #1; lat++; end
    check("first_valid_latency", 64'(lat), 64'd6);
    wait_done("basic", n);
    check("pass_length", 64'(lat + n), 64'(N_OUT * (N_IN + 3)));
    check("basic_results", 64'(hs_cnt - h0), 64'(N_OUT));
    check("basic_done_cnt", 64'(done_cnt - d0), 64'd1);
    trace_en = 1'b0;
    check("w_trace_len", 64'(wt.size()), 64'd10);
    check("x_trace_len", 64'(xt.size()), 64'd8);
    for (int k = 0; k < 10; k++) check("w_trace", 64'(k < wt.size() ? wt[k] : -1), 64'(wexp[k]));
    for (int k = 0; k < 8; k++)  check("x_trace", 64'(k < xt.size() ? xt[k] : -1), 64'(xexp[k]));

    // Saturation, positive and negative.
    xv = '{16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF};
    set_data(16'h7FFF, 16'h7FFF, 16'h0000, 16'h0000, xv, 1'b0);
    check("model_pin_satpos", 64'(model(0)), 64'h7FFF);
    simple_pass("satpos");
    set_data(16'h8000, 16'h8000, 16'h0000, 16'h0000, xv, 1'b0);
`ifdef DENSE_RELU_EN
    check("model_pin_satneg", 64'(model(0)), 64'h0000);
`else
    check("model_pin_satneg", 64'(model(0)), 64'h8000);
`endif
    simple_pass("satneg");

    // Mixed signs with a long stall in OUT and a start pulse while busy.
    xv = '{16'h0100, 16'h0300, 16'hFE00, 16'h0400};
    set_data(16'h0200, 16'h0100, 16'hFFC0, 16'h0010, xv, 1'b1);
`ifdef DENSE_RELU_EN
    check("model_pin_mixed0", 64'(model(0)), 64'h0000);
`else
    check("model_pin_mixed0", 64'(model(0)), 64'hFDC0);
`endif
    check("model_pin_mixed1", 64'(model(1)), 64'h0610);
    h0 = hs_cnt; d0 = done_cnt;
    out_ready = 1'b0;
    load_exp();
    do_start();
    lat = 0;
    while (!out_valid && lat < 50) begin @(posedge clk); #1; lat++; end
    check("stall_valid_seen", 64'(out_valid), 64'd1);
    od = out_data; oi = out_idx; wa = w_addr; xa = x_addr;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      start = (c == 5);
      check("stall_hold", 64'({out_valid, oi == out_idx, od == out_data, wa == w_addr, xa == x_addr}), 64'h1F);
    end
    start = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("after_release_bias", 64'({out_valid, busy, w_addr}), 64'({1'b0, 1'b1, 16'(BBASE + 1)}));
    wait_done("stall", n);
    check("stall_results", 64'(hs_cnt - h0), 64'(N_OUT));
    check("stall_done_cnt", 64'(done_cnt - d0), 64'd1);
    repeat (10) @(posedge clk);
    #1 check("no_relaunch", 64'(busy), 64'd0);

    // Reset in the middle of neuron 1 MAC, then a clean pass.
    xv = '{16'h0100, 16'h0200, 16'h0300, 16'h0400};
    set_data(16'h0100, 16'h0100, 16'h0080, 16'h0080, xv, 1'b0);
    h0 = hs_cnt;
    load_exp();
    do_start();
    repeat (9) @(posedge clk);
    #1 check("pre_reset_neuron0", 64'(hs_cnt - h0), 64'd1);
    check("pre_reset_busy", 64'(busy), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_ctrl", 64'({busy, done, out_valid}), 64'd0);
    check("async_rst_data", 64'({out_data, out_idx}), 64'd0);
    check("async_rst_addr", 64'({w_addr, x_addr}), 64'd0);
    exp_q.delete();
    d0 = done_cnt;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    check("no_done_on_abort", 64'(done_cnt - d0), 64'd0);
    simple_pass("post_reset");
    check("queue_empty", 64'(exp_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
